// File: rtl/kbd_pkg.sv
// Shared scan codes, decoder state type and timing helper for the
// PS/2 keyboard front end of the character controller.
package kbd_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    // Idle-clock abort window expressed in system clock cycles.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned us);
        return clk_hz / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/char_kbd_decoder_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises the keyboard lines,
// shifts in 11-bit frames on falling ps2_clk edges, checks start/parity/stop
// and aborts a stalled frame after an idle timeout.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 65_000_000,
    parameter int unsigned TIMEOUT_US  = 200,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       rx_err,
    output logic       rx_tmo
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int          TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD     = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [TW-1:0]          tmo_cnt;
    logic                   frame_ok;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // shreg[0] = start, shreg[8:1] = D0..D7, shreg[9] = parity; stop is the live sample
    assign frame_ok = ~shreg[0] & (^shreg[9:1]) & data_s;

    // Synchronisers idle high so reset never looks like a falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Bit collection, frame check and idle timeout (down-counter reloaded on each edge)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            tmo_cnt    <= TMO_LOAD;
            code       <= 8'h00;
            code_valid <= 1'b0;
            rx_err     <= 1'b0;
            rx_tmo     <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            rx_err     <= 1'b0;
            rx_tmo     <= 1'b0;
            if (fall) begin
                tmo_cnt <= TMO_LOAD;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        code       <= shreg[8:1];
                        code_valid <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_s, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tmo_cnt == '0) begin
                    rx_err  <= 1'b1;
                    rx_tmo  <= 1'b1;
                    bit_cnt <= 4'd0;
                    tmo_cnt <= TMO_LOAD;
                end else begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/char_kbd_decoder.sv
// Keyboard decoder top: receives PS/2 scan codes, tracks make/break of the
// movement keys as held levels and emits a start pulse on Enter.
//
// state       | meaning
// DEC_IDLE    | no prefix pending
// DEC_EXT     | E0 seen, next code is an extended key (or F0)
// DEC_BRK     | F0 seen, next code is a plain-key break
// DEC_EXT_BRK | E0 F0 seen, next code is an extended-key break
module char_kbd_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 65_000_000,
    parameter int unsigned TIMEOUT_US  = 200,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic stepleft,
    output logic stepright,
    output logic stepjump,
    output logic start_pls,
    output logic frame_err
);

    logic [7:0] code;
    logic       code_valid;
    logic       rx_err;
    logic       rx_tmo;

    dec_state_t dec_state;
    dec_state_t dec_next;
    logic       is_make;
    logic       is_brk;
    logic       is_ext;

    logic a_h, d_h, w_h, sp_h, l_h, r_h, u_h;
    logic a_n, d_n, w_n, sp_n, l_n, r_n, u_n;
    logic start_req;

    ps2_rx #(
        .CLK_HZ      (CLK_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .rx_err     (rx_err),
        .rx_tmo     (rx_tmo)
    );

    assign frame_err = rx_err;

    // Decoder state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dec_state <= DEC_IDLE;
        else      dec_state <= dec_next;
    end

    // Prefix tracking: classify each received code as make/break, plain/extended
    always_comb begin
        dec_next = dec_state;
        is_make  = 1'b0;
        is_brk   = 1'b0;
        is_ext   = 1'b0;
        if (code_valid) begin
            unique case (dec_state)
                DEC_IDLE: begin
                    if (code == SC_EXT)      dec_next = DEC_EXT;
                    else if (code == SC_BRK) dec_next = DEC_BRK;
                    else                     is_make  = 1'b1;
                end
                DEC_EXT: begin
                    if (code == SC_BRK) begin
                        dec_next = DEC_EXT_BRK;
                    end else if (code != SC_EXT) begin
                        is_make  = 1'b1;
                        is_ext   = 1'b1;
                        dec_next = DEC_IDLE;
                    end
                end
                DEC_BRK: begin
                    is_brk   = 1'b1;
                    dec_next = DEC_IDLE;
                end
                DEC_EXT_BRK: begin
                    is_brk   = 1'b1;
                    is_ext   = 1'b1;
                    dec_next = DEC_IDLE;
                end
                default: dec_next = DEC_IDLE;
            endcase
        end
        if (rx_tmo) dec_next = DEC_IDLE;
    end

    // Next value of each held flag; unknown codes leave every flag alone
    always_comb begin
        a_n  = a_h;
        d_n  = d_h;
        w_n  = w_h;
        sp_n = sp_h;
        l_n  = l_h;
        r_n  = r_h;
        u_n  = u_h;
        if (is_make || is_brk) begin
            if (!is_ext) begin
                if (code == SC_A)     a_n  = is_make;
                if (code == SC_D)     d_n  = is_make;
                if (code == SC_W)     w_n  = is_make;
                if (code == SC_SPACE) sp_n = is_make;
            end else begin
                if (code == SC_LEFT)  l_n  = is_make;
                if (code == SC_RIGHT) r_n  = is_make;
                if (code == SC_UP)    u_n  = is_make;
            end
        end
    end

    // Held flags and the Enter request, updated the cycle after code_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_h       <= 1'b0;
            d_h       <= 1'b0;
            w_h       <= 1'b0;
            sp_h      <= 1'b0;
            l_h       <= 1'b0;
            r_h       <= 1'b0;
            u_h       <= 1'b0;
            start_req <= 1'b0;
        end else begin
            a_h       <= a_n;
            d_h       <= d_n;
            w_h       <= w_n;
            sp_h      <= sp_n;
            l_h       <= l_n;
            r_h       <= r_n;
            u_h       <= u_n;
            start_req <= is_make && (code == SC_ENTER);
        end
    end

    // Registered outputs; left+right together is left for the movement stage to resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stepleft  <= 1'b0;
            stepright <= 1'b0;
            stepjump  <= 1'b0;
            start_pls <= 1'b0;
        end else begin
            stepleft  <= a_h | l_h;
            stepright <= d_h | r_h;
            stepjump  <= w_h | sp_h | u_h;
            start_pls <= start_req;
        end
    end

endmodule

// File: tb/tb_char_kbd_decoder.sv
// Bench for char_kbd_decoder: directed key scenarios plus a randomised
// scan-code stream, all compared against a key-state model of the keyboard.
module tb_char_kbd_decoder;

    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic stepleft, stepright, stepjump, start_pls, frame_err;

    int checks = 0;
    int failures = 0;

    // key-state model
    bit m_a, m_d, m_w, m_sp, m_l, m_r, m_u;
    bit p_ext, p_brk;
    int exp_start = 0;
    int exp_err = 0;

    // output monitors
    int n_start = 0, run_start = 0, max_start = 0;
    int n_err = 0, run_err = 0, max_err = 0;
    bit watch_left = 1'b0;
    int left_drops = 0;

    char_kbd_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .stepleft  (stepleft),
        .stepright (stepright),
        .stepjump  (stepjump),
        .start_pls (start_pls),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_pls) begin
            n_start++;
            run_start++;
            if (run_start > max_start) max_start = run_start;
        end else run_start = 0;
        if (frame_err) begin
            n_err++;
            run_err++;
            if (run_err > max_err) max_err = run_err;
        end else run_err = 0;
        if (watch_left && !stepleft) left_drops++;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^c) ^ bad_par, c, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    task automatic model_key(input logic [7:0] c, input bit ext, input bit make);
        if (!ext) begin
            case (c)
                8'h1C: m_a = make;
                8'h23: m_d = make;
                8'h1D: m_w = make;
                8'h29: m_sp = make;
                default: ;
            endcase
        end else begin
            case (c)
                8'h6B: m_l = make;
                8'h74: m_r = make;
                8'h75: m_u = make;
                default: ;
            endcase
        end
        if (make && c == 8'h5A) exp_start++;
    endtask

    // E0 marks the next key as extended, F0 marks it as released
    task automatic model_code(input logic [7:0] c);
        if (p_brk) begin
            model_key(c, p_ext, 1'b0);
            p_ext = 1'b0;
            p_brk = 1'b0;
        end else if (c == 8'hF0) begin
            p_brk = 1'b1;
        end else if (c == 8'hE0) begin
            p_ext = 1'b1;
        end else begin
            model_key(c, p_ext, 1'b1);
            p_ext = 1'b0;
        end
    endtask

    task automatic model_clear();
        {m_a, m_d, m_w, m_sp, m_l, m_r, m_u, p_ext, p_brk} = '0;
    endtask

    task automatic send_good(input logic [7:0] c);
        send_frame(c, 1'b0, 11);
        model_code(c);
    endtask

    task automatic check_all(input string tag);
        wait_clk(8);
        chk_val({tag, ".left"},  {31'd0, stepleft},  {31'd0, m_a | m_l});
        chk_val({tag, ".right"}, {31'd0, stepright}, {31'd0, m_d | m_r});
        chk_val({tag, ".jump"},  {31'd0, stepjump},  {31'd0, m_w | m_sp | m_u});
        chk_val({tag, ".starts"}, n_start, exp_start);
        chk_val({tag, ".errs"},   n_err,   exp_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [14];
        int lat;
        logic [7:0] c;
        bit bad;

        pool = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h5A, 8'h6B, 8'h74,
                 8'h75, 8'hE0, 8'hF0, 8'hE1, 8'h14, 8'h12, 8'h77};
        model_clear();

        // reset state
        wait_clk(3);
        chk_val("reset_outputs", {27'd0, stepleft, stepright, stepjump, start_pls, frame_err}, 32'd0);
        rst = 1'b1;
        wait_clk(5);

        // 'A' make with latency measured from the stop-bit falling edge
        send_frame(8'h1C, 1'b0, 10);
        ps2_data = 1'b1;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        lat = 0;
        while (!stepleft && lat < 20) begin
            wait_clk(1);
            lat++;
        end
        chk_val("latency_1c", lat, 5);
        wait_clk(HALF);
        ps2_clk = 1'b1;
        model_code(8'h1C);
        check_all("make_1c");
        send_good(8'hF0);
        check_all("brk_prefix_1c");
        send_good(8'h1C);
        check_all("brk_1c");

        // right arrow and 'D' overlap, then extended break
        send_good(8'hE0);
        send_good(8'h74);
        check_all("make_right");
        send_good(8'h23);
        send_good(8'hF0);
        send_good(8'h23);
        check_all("brk_d_right_held");
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h74);
        check_all("brk_right");

        // both directions held, then typematic repeats of 'A'
        send_good(8'h1C);
        send_good(8'h23);
        check_all("left_and_right");
        watch_left = 1'b1;
        for (int i = 0; i < 5; i++) send_good(8'h1C);
        watch_left = 1'b0;
        chk_val("typematic_glitch", left_drops, 0);
        check_all("typematic");
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'hF0);
        send_good(8'h23);
        check_all("release_both");

        // parity error then a good Space
        send_frame(8'h29, 1'b1, 11);
        exp_err++;
        check_all("bad_parity_29");
        send_good(8'h29);
        check_all("good_29");
        send_good(8'hF0);
        send_good(8'h29);
        check_all("brk_29");

        // partial frame, idle clock timeout, then Enter
        send_frame(8'h5A, 1'b0, 5);
        wait_clk(13100);
        exp_err++;
        check_all("timeout");
        send_good(8'h5A);
        check_all("enter_after_timeout");
        chk_val("start_width", max_start, 1);
        chk_val("err_width", max_err, 1);

        // randomised scan-code stream with occasional parity errors
        for (int n = 0; n < 60; n++) begin
            c = pool[$urandom_range(0, 13)];
            bad = ($urandom_range(0, 7) == 0);
            if (bad) begin
                send_frame(c, 1'b1, 11);
                exp_err++;
            end else begin
                send_good(c);
            end
            check_all("random");
        end
        chk_val("rand_start_width", max_start, 1);
        chk_val("rand_err_width", max_err, 1);

        // drain any pending prefix, make 'W', then reset mid-frame
        send_good(8'h14);
        send_good(8'h1D);
        check_all("make_1d");
        send_frame(8'h75, 1'b0, 4);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_val("async_reset_outputs", {27'd0, stepleft, stepright, stepjump, start_pls, frame_err}, 32'd0);
        model_clear();
        wait_clk(3);
        rst = 1'b1;
        wait_clk(5);
        check_all("after_reset");
        send_good(8'h1D);
        check_all("make_1d_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
